// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared single-cycle ALU.
// Round-robin grant, one issue register, one response slot per requester.
package alu_pkg;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_NOP  = 5'd31;
endpackage

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [4:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_rsp_c,
  output logic             r0_rsp_zero,
  output logic             r0_rsp_ovf,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [4:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_rsp_c,
  output logic             r1_rsp_zero,
  output logic             r1_rsp_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,
  input  logic             alu_ovf
);

  logic             s1_valid;
  logic             s1_id;
  logic [4:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             last_grant;
  logic             elig0;
  logic             elig1;
  logic             acc0;
  logic             acc1;
  logic             ovf_m;

  // Eligibility uses registered state only, so rsp_ready never reaches ready.
  assign elig0 = !r0_rsp_valid && !(s1_valid && !s1_id);
  assign elig1 = !r1_rsp_valid && !(s1_valid && s1_id);

  assign r0_ready = elig0 && (!(r1_valid && elig1) || last_grant);
  assign r1_ready = elig1 && (!(r0_valid && elig0) || !last_grant);

  assign acc0 = r0_valid && r0_ready;
  assign acc1 = r1_valid && r1_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_op      <= ALU_NOP;
      s1_a       <= '0;
      s1_b       <= '0;
      last_grant <= (PRIO_INIT == 0);
    end else begin
      s1_valid <= acc0 || acc1;
      unique case (1'b1)
        acc0: begin
          s1_id      <= 1'b0;
          s1_op      <= r0_op;
          s1_a       <= r0_a;
          s1_b       <= r0_b;
          last_grant <= 1'b0;
        end
        acc1: begin
          s1_id      <= 1'b1;
          s1_op      <= r1_op;
          s1_a       <= r1_a;
          s1_b       <= r1_b;
          last_grant <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_op = s1_valid ? s1_op : ALU_NOP;
  assign alu_a  = s1_valid ? s1_a : '0;
  assign alu_b  = s1_valid ? s1_b : '0;

  // ALU overflow is only meaningful for add/sub; it holds stale data otherwise.
  assign ovf_m = alu_ovf && (s1_op == ALU_ADD || s1_op == ALU_SUB);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_rsp_valid <= 1'b0;
      r0_rsp_c     <= '0;
      r0_rsp_zero  <= 1'b0;
      r0_rsp_ovf   <= 1'b0;
    end else if (s1_valid && !s1_id) begin
      r0_rsp_valid <= 1'b1;
      r0_rsp_c     <= alu_c;
      r0_rsp_zero  <= alu_zero;
      r0_rsp_ovf   <= ovf_m;
    end else if (r0_rsp_valid && r0_rsp_ready) begin
      r0_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_rsp_valid <= 1'b0;
      r1_rsp_c     <= '0;
      r1_rsp_zero  <= 1'b0;
      r1_rsp_ovf   <= 1'b0;
    end else if (s1_valid && s1_id) begin
      r1_rsp_valid <= 1'b1;
      r1_rsp_c     <= alu_c;
      r1_rsp_zero  <= alu_zero;
      r1_rsp_ovf   <= ovf_m;
    end else if (r1_rsp_valid && r1_rsp_ready) begin
      r1_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed ops, queue scoreboard.
// Expected results are hand-computed constants pushed at accept time.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rstn;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
  logic [4:0]  r0_op;
  logic [31:0] r0_a, r0_b, r0_rsp_c;
  logic        r0_rsp_zero, r0_rsp_ovf;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
  logic [4:0]  r1_op;
  logic [31:0] r1_a, r1_b, r1_rsp_c;
  logic        r1_rsp_zero, r1_rsp_ovf;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_op;
  logic        alu_zero, alu_ovf;

  alu_arbiter #(.WIDTH(32), .PRIO_INIT(0)) dut (
    .clk(clk), .rstn(rstn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
    .r0_a(r0_a), .r0_b(r0_b),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_c(r0_rsp_c), .r0_rsp_zero(r0_rsp_zero),
    .r0_rsp_ovf(r0_rsp_ovf),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
    .r1_a(r1_a), .r1_b(r1_b),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_c(r1_rsp_c), .r1_rsp_zero(r1_rsp_zero),
    .r1_rsp_ovf(r1_rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; overflow output holds its last add/sub value otherwise.
  logic [31:0] c_calc;
  logic        ov_calc;
  logic        ovf_hold = 1'b0;
  logic        is_arith;
  always_comb begin
    c_calc   = '0;
    ov_calc  = 1'b0;
    is_arith = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
    case (alu_op)
      ALU_ADD: begin
        c_calc  = alu_a + alu_b;
        ov_calc = (alu_a[31] == alu_b[31]) && (c_calc[31] != alu_a[31]);
      end
      ALU_SUB: begin
        c_calc  = alu_a - alu_b;
        ov_calc = (alu_a[31] != alu_b[31]) && (c_calc[31] != alu_a[31]);
      end
      ALU_AND: c_calc = alu_a & alu_b;
      ALU_OR:  c_calc = alu_a | alu_b;
      ALU_XOR: c_calc = alu_a ^ alu_b;
      default: c_calc = '0;
    endcase
    alu_c    = c_calc;
    alu_zero = (c_calc == 32'd0);
    alu_ovf  = is_arith ? ov_calc : ovf_hold;
  end
  always @(posedge clk) if (is_arith) ovf_hold <= ov_calc;

  typedef struct {
    logic [31:0] c;
    logic        z;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   order[$];
  int   acc1_cyc[$];
  int   checks = 0;
  int   errors = 0;
  logic [4:0] acc_alu_op;
  logic p0 = 1'b0;
  logic p1 = 1'b0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void mon(int id, logic v, logic rdy, logic prev,
                              logic [31:0] c, logic z, logic o);
    exp_t e;
    int   n;
    n = (id == 0) ? q0.size() : q1.size();
    if (v && !prev) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL r%0d unexpected response: got c=%h", id, c);
      end else begin
        e = (id == 0) ? q0[0] : q1[0];
        chk($sformatf("r%0d latency", id), cyc - e.cyc, 2);
      end
    end
    if (v && rdy && n > 0) begin
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("r%0d c", id), c, e.c);
      chk($sformatf("r%0d zero", id), {31'd0, z}, {31'd0, e.z});
      chk($sformatf("r%0d ovf", id), {31'd0, o}, {31'd0, e.o});
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        mon(0, r0_rsp_valid, r0_rsp_ready, p0, r0_rsp_c, r0_rsp_zero,
            r0_rsp_ovf);
        mon(1, r1_rsp_valid, r1_rsp_ready, p1, r1_rsp_c, r1_rsp_zero,
            r1_rsp_ovf);
        p0 = r0_rsp_valid;
        p1 = r1_rsp_valid;
      end else begin
        p0 = 1'b0;
        p1 = 1'b0;
      end
    end
  end

  task automatic issue(input int id, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic z,
                       input logic o);
    int   n;
    logic rdy;
    exp_t e;
    @(negedge clk);
    if (id == 0) begin
      r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b;
    end else begin
      r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b;
    end
    n = 0;
    forever begin
      #2;
      rdy = (id == 0) ? r0_ready : r1_ready;
      if (rdy || n >= 60) break;
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL r%0d accept timeout: got ready=0 expected 1", id);
    end else begin
      e.c = c; e.z = z; e.o = o; e.cyc = cyc;
      acc_alu_op = alu_op;
      order.push_back(id);
      if (id == 0) q0.push_back(e);
      else begin
        q1.push_back(e);
        acc1_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    if (id == 0) r0_valid = 1'b0;
    else r1_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst r0_rsp_valid", {31'd0, r0_rsp_valid}, 0);
    chk("rst r1_rsp_valid", {31'd0, r1_rsp_valid}, 0);
    chk("rst alu_op", {27'd0, alu_op}, {27'd0, ALU_NOP});
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0;
    r0_valid = 0; r0_op = ALU_NOP; r0_a = 0; r0_b = 0;
    r1_valid = 0; r1_op = ALU_NOP; r1_a = 0; r1_b = 0;
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    #1;
    chk("reset r0_rsp_valid", {31'd0, r0_rsp_valid}, 0);
    chk("reset r1_rsp_valid", {31'd0, r1_rsp_valid}, 0);
    chk("reset r0_rsp_c", r0_rsp_c, 0);
    chk("reset r1_rsp_c", r1_rsp_c, 0);
    chk("reset zero/ovf", {28'd0, r0_rsp_zero, r0_rsp_ovf,
                           r1_rsp_zero, r1_rsp_ovf}, 0);
    chk("reset alu_op", {27'd0, alu_op}, {27'd0, ALU_NOP});
    chk("reset alu_a", alu_a, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Single op with pipeline visibility.
    issue(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    chk("single nop at accept", {27'd0, acc_alu_op}, {27'd0, ALU_NOP});
    @(negedge clk);
    chk("single alu_op k+1", {27'd0, alu_op}, {27'd0, ALU_ADD});
    chk("single alu_a k+1", alu_a, 32'd5);
    chk("single alu_b k+1", alu_b, 32'd7);
    @(negedge clk);
    chk("single alu_op k+2", {27'd0, alu_op}, {27'd0, ALU_NOP});
    chk("single rsp_valid k+2", {31'd0, r0_rsp_valid}, 1);

    // Overflow masking with a stale ALU overflow.
    issue(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    issue(1, ALU_OR, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Round robin with both requesters continuously valid.
    repeat (3) @(negedge clk);
    order.delete();
    fork
      begin
        issue(0, ALU_ADD, 32'd10, 32'd1, 32'd11, 1'b0, 1'b0);
        issue(0, ALU_SUB, 32'd100, 32'd30, 32'd70, 1'b0, 1'b0);
        issue(0, ALU_XOR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
      end
      begin
        issue(1, ALU_AND, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0, 1'b0);
        issue(1, ALU_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        issue(1, ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
      end
    join
    chk("rr accept count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++)
      chk($sformatf("rr order %0d", i), order[i], i % 2);

    // Back-pressure on R0 while R1 keeps going.
    repeat (3) @(negedge clk);
    r0_rsp_ready = 1'b0;
    issue(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    acc1_cyc.delete();
    fork
      begin
        n = 0;
        while (!r0_rsp_valid && n < 10) begin
          @(negedge clk);
          n++;
        end
        chk("bp r0_rsp_valid", {31'd0, r0_rsp_valid}, 1);
        repeat (10) begin
          @(negedge clk);
          chk("bp r0_ready", {31'd0, r0_ready}, 0);
          chk("bp r0_rsp_c", r0_rsp_c, 32'd2);
        end
      end
      begin
        issue(1, ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        issue(1, ALU_ADD, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1);
        issue(1, ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
      end
    join
    chk("bp r1 accepts", acc1_cyc.size(), 3);
    for (int i = 1; i < acc1_cyc.size(); i++)
      chk("bp r1 spacing", acc1_cyc[i] - acc1_cyc[i-1], 3);
    @(posedge clk);
    #1 r0_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset one cycle after an R1 accept; the op is dropped.
    issue(1, ALU_ADD, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0);
    pulse_reset();
    repeat (4) begin
      @(negedge clk);
      chk("post-rst r1_rsp_valid", {31'd0, r1_rsp_valid}, 0);
    end
    order.delete();
    fork
      issue(0, ALU_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0);
      issue(1, ALU_XOR, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
    join
    chk("post-rst collision count", order.size(), 2);
    if (order.size() > 0) chk("post-rst first grant", order[0], 0);

    // Priority state must return to its reset value, not keep history.
    repeat (3) @(negedge clk);
    issue(0, ALU_AND, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    pulse_reset();
    order.delete();
    fork
      issue(0, ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
      issue(1, ALU_ADD, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0);
    join
    chk("rst prio count", order.size(), 2);
    if (order.size() > 0) chk("rst prio first grant", order[0], 0);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle `alu` between two requesters (R0, R1), e.g. the main execute path and an auxiliary address/compare unit. Each requester uses a valid/ready operand port and a valid/ready response port. Accepted operations are registered, driven into the ALU for one cycle, and the result is captured into a one-entry response buffer per requester. Round-robin arbitration resolves collisions.

## Interface
- `WIDTH`, 32: operand and result width; must match the ALU.
- `PRIO_INIT`, 0: requester that wins the first collision after reset.
- `clk` in 1: clock; all state updates on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `r0_valid` in 1: R0 operation request.
- `r0_ready` out 1: R0 request accepted this cycle when high with `r0_valid`.
- `r0_op` in 5: ALU operation code, from the shared encoding header.
- `r0_a`, `r0_b` in WIDTH: operands.
- `r0_rsp_valid` out 1: R0 result held.
- `r0_rsp_ready` in 1: R0 consumes result.
- `r0_rsp_c` out WIDTH: result.
- `r0_rsp_zero` out 1: result equals 0.
- `r0_rsp_ovf` out 1: signed overflow.
- `r1_*`: identical set for R1.
- `alu_a`, `alu_b` out WIDTH: to ALU A/B.
- `alu_op` out 5: to ALU ALUOp.
- `alu_c` in WIDTH: from ALU C.
- `alu_zero` in 1: from ALU Zero.
- `alu_ovf` in 1: from ALU Overflow.

## Operation
- **Issue register S1** holds `s1_valid`, `s1_id` (0/1), `s1_op`, `s1_a`, `s1_b`. The ALU inputs come only from S1.
- **Idle ALU inputs.** When `s1_valid`=0: `alu_op`=`ALU_NOP`, `alu_a`=`alu_b`=0.
- **Eligibility.** Ri is eligible when `ri_rsp_valid`=0 and not (`s1_valid` and `s1_id`=i). No second operation is accepted from a requester while one is in flight or unconsumed.
- **Grant.**
  - Only one requester valid and eligible: it gets `ri_ready`=1.
  - Both valid and eligible: the one not equal to `last_grant` wins.
  - `last_grant` updates on every accept and resets to 1-`PRIO_INIT`.
  - `ri_ready` is combinational. It may depend on the other requester's valid, never on its own valid. At most one `ri_ready` is high per cycle.
- **Accept** (`ri_valid` & `ri_ready`): S1 loads id=i, op, a, b, and `s1_valid`=1. With no accept, `s1_valid`=0 on the next edge.
- **Capture.** When `s1_valid`=1, at the next edge the response slot `s1_id` loads `c`=`alu_c` and `zero`=`alu_zero`, and sets `rsp_valid`.
  - `ovf` = `alu_ovf` only when `s1_op` is `ALU_ADD` or `ALU_SUB`; otherwise 0. The ALU Overflow output holds stale values for other ops.
- **Response slot.**
  - Holds `c`/`zero`/`ovf` stable while `rsp_valid`=1.
  - Clears `rsp_valid` on `rsp_valid` & `rsp_ready`.
  - `rsp_ready` while `rsp_valid`=0 is ignored.
- **Reset.** Asynchronous assert clears everything, including in-flight work; operations in flight are dropped silently.
  - All `ri_ready` are computed from cleared state.
  - All `rsp_valid`=0, `rsp_c`=0, `rsp_zero`=0, `rsp_ovf`=0.
  - `s1_valid`=0, so `alu_op`=`ALU_NOP` and `alu_a`=`alu_b`=0.

## Timing
- **Latency.** Handshake in cycle k → ALU evaluates in cycle k+1 → `rsp_valid` high from cycle k+2.
- **Throughput.**
  - One accept per cycle overall.
  - Per requester at most one accept every 3 cycles (accept k, blocked k+1..k+2, eligible k+3 if the response is consumed in k+2).
  - Alternating R0/R1 sustains 1 op/cycle.
- **Same-cycle events.** A response handshake and a re-accept from the same requester in the same cycle is not allowed. Eligibility uses registered `rsp_valid`, so no combinational path runs from `rsp_ready` to `ri_ready`.
- **Rejected request.** A request with `ri_ready`=0 must hold (valid, op, a, b stable) until accepted; the block does not buffer it.
- **Back-pressure.** An unconsumed response blocks only its own requester; the other continues at full rate.

## Test plan
- **Single op.** R0 issues `ALU_ADD` a=5, b=7 in cycle 0, R1 idle → `r0_ready`=1 in cycle 0; `r0_rsp_valid`=1 in cycle 2 with c=12, zero=0, ovf=0; `alu_op`=`ALU_NOP` in cycles 0 and 2.
- **Overflow masking.** R1 `ALU_ADD` 0x7FFFFFFF+1 → c=0x80000000, ovf=1. Then R1 `ALU_OR` 0,0 → c=0, zero=1, ovf=0 even though ALU Overflow is stale 1.
- **Round robin.** Both requesters hold valid continuously with `PRIO_INIT`=0 and responses consumed immediately → accept order R0,R1,R0,R1…, one accept per cycle, and each response routed to the correct requester (distinct operands per requester).
- **Back-pressure.** R0 `rsp_ready`=0 for 10 cycles after its first result → `r0_ready` stays 0 and `r0_rsp_c` is stable. R1 gets accepted every 3 cycles with its responses consumed.
- **Reset mid-operation.** Assert `rstn`=0 asynchronously one cycle after an R1 accept → immediately all `rsp_valid`=0 and `alu_op`=`ALU_NOP`. After release, no stale response appears and the first collision is granted to R0.
